aes_iter_engine: RTL and testbench
==================================

Name: aes_iter_engine

Overview:
Iterative AES block-cipher encryption core (FIPS-197) with a parametrised key size and a full valid/ready handshake on input and output. One shared round datapath executes one round per clock, and round keys are expanded on the fly. This replaces the fully unrolled 128-bit engine where area matters or AES-256 is needed. It sits between the block-source FIFO and the ciphertext sink, and supports output backpressure.

Parameters:
KEY_BITS, 128, key length; legal values 128 or 256; any other value is an elaboration error; Nr = 10 (128) or 14 (256)

Ports:
clk        input   1         single clock; all state on rising edge
rst        input   1         asynchronous, active-high reset
anahtar    input   KEY_BITS  cipher key; byte 0 at MSBs; sampled only at accept
blok       input   128       plaintext; blok[127:120] = state byte s(0,0), column-major
g_gecerli  input   1         input valid
hazir      output  1         input ready; accept = g_gecerli & hazir
sifre      output  128       ciphertext, same byte order as blok
c_gecerli  output  1         output valid
c_hazir    input   1         output ready from sink; transfer = c_gecerli & c_hazir

Behaviour:
- Reset (async assert, sync release): FSM=IDLE; sifre=0; c_gecerli=0; round counter=0; key registers=0. hazir=1 as soon as rst deasserts.
- FSM states: IDLE, RUN, DONE.
- IDLE: hazir=1. On accept:
  - state <= blok ^ K[127:0].
  - key registers <= anahtar.
  - round counter <= 1.
  - FSM -> RUN.
- RUN: hazir=0. Each cycle applies round r = SubBytes, ShiftRows, MixColumns, AddRoundKey(rk_r). The next round key is computed combinationally from the key registers (RotWord/SubWord/Rcon), then registered.
  - For KEY_BITS=256, keep two 128-bit key halves. Even-step words use SubWord(RotWord)^Rcon; odd-step words use SubWord only. Rcon advances once per 8 words.
- At r = Nr, MixColumns is skipped (final round). The result is written to sifre, c_gecerli <= 1, and FSM -> DONE.
- Latency: accept at edge E; c_gecerli is high after edge E+Nr (10 or 14 cycles).
- DONE: sifre and c_gecerli are held stable until transfer.
  - hazir = c_hazir (combinational), giving back-to-back throughput of one block per Nr+1 cycles.
  - Transfer with no accept: c_gecerli <= 0, FSM -> IDLE.
  - Transfer with simultaneous accept: c_gecerli <= 0, load the new block as in IDLE, FSM -> RUN.
- sifre holds its last value after transfer; it is not cleared.
- g_gecerli while busy (RUN, or DONE without c_hazir) is ignored; the source must hold it.
- anahtar and blok are don't-care outside the accept cycle. A new key may differ per block; there is no key-caching requirement.
- Reset mid-RUN or in DONE: the block is discarded immediately; c_gecerli falls asynchronously; no partial output is ever flagged valid.
- All arithmetic is GF(2^8) with xtime reduction polynomial 0x11b. The S-box is a 256-entry combinational table shared by the datapath (16 instances) and the key path (4 instances).
- hazir, c_gecerli and sifre never produce X after reset.

Test Plan:
- KEY_BITS=128: anahtar=2b7e151628aed2a6abf7158809cf4f3c, blok=3243f6a8885a308d313198a2e0370734 -> sifre=3925841d02dc09fbdc118597196a0b32, with c_gecerli rising exactly 10 cycles after accept.
- KEY_BITS=128: anahtar=000102...0f, blok=00112233445566778899aabbccddeeff -> 69c4e0d86a7b0430d8cdb78070b4c55a. KEY_BITS=256: anahtar=000102...1f, same blok -> 8ea2b7ca516745bfeafc49904b496089, with latency 14.
- Backpressure: c_hazir=0 for 20 cycles after completion -> sifre and c_gecerli stable and hazir=0 throughout. Then c_hazir=1 with g_gecerli=1 -> transfer and accept occur in the same cycle.
- Streaming: hold c_hazir=1 and g_gecerli=1 with 4 vectors -> four correct ciphertexts in order, with 11-cycle spacing (128-bit).
- Reset asserted at round 5 -> c_gecerli=0 and hazir=1 after release. Then the Appendix B vector -> correct result with no residual state.
- g_gecerli pulsed and blok changed mid-RUN -> ignored; the first block's ciphertext is unaffected.

Source files
------------

// File: rtl/aes_iter_engine_if.sv
// Block handshake bundle for aes_iter_engine: key/plaintext in, ciphertext out,
// each direction with its own valid/ready pair.
interface aes_iter_engine_if #(
  parameter int KEY_BITS = 128
);
  logic [KEY_BITS-1:0] anahtar;
  logic [127:0]        blok;
  logic                g_gecerli;
  logic                hazir;
  logic [127:0]        sifre;
  logic                c_gecerli;
  logic                c_hazir;

  modport master (
    output anahtar, blok, g_gecerli, c_hazir,
    input  hazir, sifre, c_gecerli
  );

  modport slave (
    input  anahtar, blok, g_gecerli, c_hazir,
    output hazir, sifre, c_gecerli
  );
endinterface

// File: rtl/aes_iter_engine.sv
// Iterative AES-128/256 encryptor: one round per clock on a shared datapath,
// round keys expanded on the fly, valid/ready on both sides.
module aes_iter_engine #(
  parameter int KEY_BITS = 128
) (
  input  logic              clk,
  input  logic              rst,
  aes_iter_engine_if.slave  bus
);

  localparam logic [3:0] NR = (KEY_BITS == 256) ? 4'd14 : 4'd10;

  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry x sits at bit 8*(255-x)+7 of the packed table, i.e. {~x, 3'b111}.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TABLE[{~x, 3'b111} -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Four new schedule words from the previous four, seeded by the last word.
  function automatic logic [127:0] expand_key(input logic [127:0] prev,
                                              input logic [31:0]  last,
                                              input logic         use_rot,
                                              input logic [7:0]   rc);
    logic [31:0] t, w0, w1, w2, w3;
    t  = use_rot ? (sub_word({last[23:0], last[31:24]}) ^ {rc, 24'h0}) : sub_word(last);
    w0 = prev[127:96] ^ t;
    w1 = prev[95:64]  ^ w0;
    w2 = prev[63:32]  ^ w1;
    w3 = prev[31:0]   ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // SubBytes + ShiftRows; state byte (r,c) lives at index 4c+r from the MSB.
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = sbox(s[127-8*(4*((c+r)%4)+r) -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = s[127-32*c -: 32];
      o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                           a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                           a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                           xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return o;
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        r_fsm, w_fsm_next;
  logic [127:0]  r_state, r_sifre;
  logic [3:0]    r_round;
  logic          r_c_gecerli;
  logic          w_hazir, w_accept, w_transfer, w_running, w_last;
  logic [127:0]  w_rk, w_rk0, w_sb_sr, w_round_out;

  assign w_accept   = bus.g_gecerli & w_hazir;
  assign w_transfer = r_c_gecerli & bus.c_hazir;
  assign w_running  = (r_fsm == S_RUN);
  assign w_last     = (r_round == NR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_fsm <= S_IDLE;
    else     r_fsm <= w_fsm_next;
  end

  // NOTE: defaulting every always_comb output first keeps it a pure mux, never a latch.
  always_comb begin
    w_fsm_next = r_fsm;
    case (r_fsm)
      S_IDLE:  if (w_accept) w_fsm_next = S_RUN;
      S_RUN:   if (w_last) w_fsm_next = S_DONE;
      S_DONE:  if (w_transfer) w_fsm_next = w_accept ? S_RUN : S_IDLE;
      default: w_fsm_next = S_IDLE;
    endcase
  end

  // Ready is withheld while reset is held so no block is handed over into reset.
  always_comb begin
    w_hazir = 1'b0;
    case (r_fsm)
      S_IDLE:  w_hazir = 1'b1;
      S_DONE:  w_hazir = bus.c_hazir;
      default: w_hazir = 1'b0;
    endcase
    w_hazir = w_hazir & ~rst;
  end

  generate
    if (KEY_BITS == 128) begin : g_key128
      logic [127:0] r_key;
      assign w_rk0 = bus.anahtar[127:0];
      assign w_rk  = expand_key(r_key, r_key[31:0], 1'b1, rcon(r_round));
      // NOTE: key state is ordinary flops, not a memory, so it is cleared on reset too.
      always_ff @(posedge clk or posedge rst) begin
        if (rst)            r_key <= '0;
        else if (w_accept)  r_key <= bus.anahtar;
        else if (w_running) r_key <= w_rk;
      end
    end else if (KEY_BITS == 256) begin : g_key256
      // r_key_a/r_key_b hold round keys r-1 and r; round r+1 is derived from them.
      logic [127:0] r_key_a, r_key_b;
      logic [3:0]   w_rc_idx;
      assign w_rc_idx = (r_round + 4'd1) >> 1;
      assign w_rk0    = bus.anahtar[255:128];
      assign w_rk     = r_key_b;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_key_a <= '0;
          r_key_b <= '0;
        end else if (w_accept) begin
          r_key_a <= bus.anahtar[255:128];
          r_key_b <= bus.anahtar[127:0];
        end else if (w_running) begin
          r_key_a <= r_key_b;
          r_key_b <= expand_key(r_key_a, r_key_b[31:0], r_round[0], rcon(w_rc_idx));
        end
      end
    end else begin : g_bad_key_bits
      $error("aes_iter_engine: KEY_BITS must be 128 or 256");
    end
  endgenerate

  assign w_sb_sr     = sub_shift(r_state);
  assign w_round_out = (w_last ? w_sb_sr : mix_columns(w_sb_sr)) ^ w_rk;

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= '0;
      r_round     <= '0;
      r_sifre     <= '0;
      r_c_gecerli <= 1'b0;
    end else begin
      if (w_accept) begin
        r_state <= bus.blok ^ w_rk0;
        r_round <= 4'd1;
      end else if (w_running) begin
        r_state <= w_round_out;
        r_round <= w_last ? 4'd0 : r_round + 4'd1;
        if (w_last) begin
          r_sifre     <= w_round_out;
          r_c_gecerli <= 1'b1;
        end
      end
      if (w_transfer) r_c_gecerli <= 1'b0;
    end
  end

  assign bus.hazir     = w_hazir;
  assign bus.sifre     = r_sifre;
  assign bus.c_gecerli = r_c_gecerli;

endmodule

// File: tb/tb_aes_iter_engine.sv
// Directed bench for aes_iter_engine: FIPS-197 / SP800-38A vectors on a 128-bit
// and a 256-bit instance, covering latency, backpressure, streaming and reset.
module tb_aes_iter_engine;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  aes_iter_engine_if #(.KEY_BITS(128)) bus128();
  aes_iter_engine_if #(.KEY_BITS(256)) bus256();

  aes_iter_engine #(.KEY_BITS(128)) dut128 (.clk(clk), .rst(rst), .bus(bus128.slave));
  aes_iter_engine #(.KEY_BITS(256)) dut256 (.clk(clk), .rst(rst), .bus(bus256.slave));

  localparam logic [127:0] K_FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P_FIPS = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C_FIPS = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] K_C1   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P_C    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C_C1   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [255:0] K_C3   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] C_C3   = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [255:0] K_S256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] P_S1   = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] C_S1   = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
  localparam logic [127:0] C_S256 = 128'hf3eed1bdb5d2a03c064b5a7e3db181f8;
  localparam logic [127:0] P_S2   = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] C_S2   = 128'hf5d3d58503b9699de785895a96fdbaaf;
  localparam logic [127:0] P_S3   = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
  localparam logic [127:0] C_S3   = 128'h43b1cd7f598ece23881b00e3ed030688;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Wait for ready, present one block, and return at #1 after the accept edge.
  task automatic start128(input string tag, input logic [127:0] key, input logic [127:0] pt);
    int w = 0;
    while (bus128.hazir !== 1'b1 && w < 50) begin
      @(posedge clk); #1; w++;
    end
    check({tag, " ready"}, bus128.hazir, 1);
    bus128.anahtar = key; bus128.blok = pt; bus128.g_gecerli = 1'b1;
    @(posedge clk); #1;
    bus128.g_gecerli = 1'b0; bus128.anahtar = ~key; bus128.blok = ~pt;
  endtask

  // Count edges from accept to c_gecerli; optionally wave a second block mid-RUN.
  task automatic finish128(input string tag, input logic [127:0] exp, input bit glitch);
    int lat = 0;
    while (bus128.c_gecerli !== 1'b1 && lat < 40) begin
      if (glitch && lat == 3) begin
        bus128.g_gecerli = 1'b1; bus128.blok = P_S1; bus128.anahtar = K_FIPS;
        #1 check({tag, " busy hazir"}, bus128.hazir, 0);
      end
      if (glitch && lat == 5) bus128.g_gecerli = 1'b0;
      @(posedge clk); #1; lat++;
    end
    check({tag, " latency"}, lat, 10);
    check({tag, " sifre"}, bus128.sifre, exp);
  endtask

  task automatic run256(input string tag, input logic [255:0] key, input logic [127:0] pt,
                        input logic [127:0] exp);
    int lat = 0;
    int w = 0;
    while (bus256.hazir !== 1'b1 && w < 50) begin
      @(posedge clk); #1; w++;
    end
    check({tag, " ready"}, bus256.hazir, 1);
    bus256.anahtar = key; bus256.blok = pt; bus256.g_gecerli = 1'b1;
    @(posedge clk); #1;
    bus256.g_gecerli = 1'b0; bus256.anahtar = ~key; bus256.blok = ~pt;
    while (bus256.c_gecerli !== 1'b1 && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    check({tag, " latency"}, lat, 14);
    check({tag, " sifre"}, bus256.sifre, exp);
  endtask

  logic [127:0] s_key [4];
  logic [127:0] s_pt  [4];
  logic [127:0] s_ct  [4];
  logic [127:0] s_out [4];
  int           s_t   [4];

  initial begin
    int idx, n, bad_s, bad_v, bad_h;
    bit acc;

    s_key = '{K_FIPS, K_FIPS, K_FIPS, K_C1};
    s_pt  = '{P_S1, P_S2, P_S3, P_C};
    s_ct  = '{C_S1, C_S2, C_S3, C_C1};

    bus128.anahtar = '0; bus128.blok = '0; bus128.g_gecerli = 1'b0; bus128.c_hazir = 1'b1;
    bus256.anahtar = '0; bus256.blok = '0; bus256.g_gecerli = 1'b0; bus256.c_hazir = 1'b1;

    // Reset values, then ready as soon as reset is released.
    #2;
    check("rst c_gecerli128", bus128.c_gecerli, 0);
    check("rst sifre128", bus128.sifre, 0);
    check("rst c_gecerli256", bus256.c_gecerli, 0);
    check("rst sifre256", bus256.sifre, 0);
    #20 rst = 1'b0;
    #1;
    check("post-rst hazir128", bus128.hazir, 1);
    check("post-rst hazir256", bus256.hazir, 1);
    @(posedge clk); #1;

    // FIPS-197 Appendix B, then output held after the transfer.
    start128("fipsB", K_FIPS, P_FIPS);
    finish128("fipsB", C_FIPS, 1'b0);
    @(posedge clk); #1;
    check("fipsB transferred", bus128.c_gecerli, 0);
    check("fipsB sifre held", bus128.sifre, C_FIPS);

    // Appendix C.1 with a stray valid pulse and changed inputs mid-RUN.
    start128("c1", K_C1, P_C);
    finish128("c1", C_C1, 1'b1);
    @(posedge clk); #1;

    // AES-256 vectors.
    run256("c3", K_C3, P_C, C_C3);
    @(posedge clk); #1;
    run256("sp256", K_S256, P_S1, C_S256);
    @(posedge clk); #1;
    check("sp256 transferred", bus256.c_gecerli, 0);

    // Streaming: source and sink always ready, four blocks back to back.
    idx = 0; n = 0;
    bus128.anahtar = s_key[0]; bus128.blok = s_pt[0]; bus128.g_gecerli = 1'b1;
    for (int cyc = 1; cyc <= 80 && n < 4; cyc++) begin
      acc = bus128.g_gecerli & bus128.hazir;
      @(posedge clk); #1;
      if (acc) begin
        idx++;
        if (idx < 4) begin
          bus128.anahtar = s_key[idx]; bus128.blok = s_pt[idx];
        end else begin
          bus128.g_gecerli = 1'b0;
        end
      end
      if (bus128.c_gecerli === 1'b1) begin
        s_out[n] = bus128.sifre; s_t[n] = cyc; n++;
      end
    end
    bus128.g_gecerli = 1'b0;
    check("stream count", n, 4);
    for (int k = 0; k < n; k++) check($sformatf("stream ct%0d", k), s_out[k], s_ct[k]);
    for (int k = 1; k < n; k++) check($sformatf("stream gap%0d", k), s_t[k] - s_t[k-1], 11);
    @(posedge clk); #1;

    // Backpressure: sink stalls 20 cycles while the source holds the next block.
    bus128.c_hazir = 1'b0;
    start128("bp", K_FIPS, P_S1);
    finish128("bp", C_S1, 1'b0);
    bus128.anahtar = K_FIPS; bus128.blok = P_S2; bus128.g_gecerli = 1'b1;
    bad_s = 0; bad_v = 0; bad_h = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (bus128.sifre !== C_S1) bad_s++;
      if (bus128.c_gecerli !== 1'b1) bad_v++;
      if (bus128.hazir !== 1'b0) bad_h++;
    end
    check("bp sifre unstable cycles", bad_s, 0);
    check("bp c_gecerli dropped cycles", bad_v, 0);
    check("bp hazir high cycles", bad_h, 0);
    bus128.c_hazir = 1'b1;
    #1 check("bp hazir follows c_hazir", bus128.hazir, 1);
    @(posedge clk); #1;
    check("bp transfer", bus128.c_gecerli, 0);
    check("bp accepted", bus128.hazir, 0);
    bus128.g_gecerli = 1'b0; bus128.blok = '0;
    finish128("bp next", C_S2, 1'b0);
    @(posedge clk); #1;

    // Reset in the middle of a run.
    start128("rst-run", K_FIPS, P_S3);
    repeat (4) begin
      @(posedge clk); #1;
    end
    #2 rst = 1'b1;
    #1 check("rst-run c_gecerli", bus128.c_gecerli, 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("rst-run hazir", bus128.hazir, 1);
    check("rst-run c_gecerli after", bus128.c_gecerli, 0);

    // Reset while a result waits: valid must fall with no clock edge.
    bus128.c_hazir = 1'b0;
    start128("rst-done", K_C1, P_C);
    finish128("rst-done", C_C1, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("rst-done c_gecerli", bus128.c_gecerli, 0);
    check("rst-done sifre", bus128.sifre, 0);
    #10 rst = 1'b0;
    bus128.c_hazir = 1'b1;
    #1;

    // Clean run after reset.
    start128("post-rst", K_FIPS, P_FIPS);
    finish128("post-rst", C_FIPS, 1'b0);
    @(posedge clk); #1;
    check("post-rst transferred", bus128.c_gecerli, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
